// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU round-robin scheduler: op codes, response
// codes, scheduler states and the command/response records it carries.
package fpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_ILLEGAL = 2'b10
  } rsp_err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } sched_state_e;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  op_sel;
  } fpu_cmd_t;

  typedef struct packed {
    logic [31:0] result;
    logic        overflow;
    rsp_err_e    err;
  } fpu_rsp_t;

  function automatic logic is_legal_op(input logic [2:0] op_sel);
    return (op_sel == OP_ADD) || (op_sel == OP_SUB) || (op_sel == OP_MUL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant_i, searched
// cyclically. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    cand          = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_i) + k) % NUM_REQ);
      if (!grant_valid_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Shares one FPU wrapper between NUM_REQ requesters: round-robin accept, one-cycle
// issue strobe, done-edge wait with timeout, one-hot response pulse to the issuer.
module fpu_rr_scheduler
  import fpu_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*32-1:0] req_op1,
  input  logic [NUM_REQ*32-1:0] req_op2,
  input  logic [NUM_REQ*3-1:0] req_op_sel,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [31:0]          rsp_result,
  output logic                 rsp_overflow,
  output logic [1:0]           rsp_err,
  output logic [31:0]          fpu_op1,
  output logic [31:0]          fpu_op2,
  output logic [2:0]           fpu_op_sel,
  output logic                 fpu_op_strobe,
  input  logic [31:0]          fpu_result,
  input  logic                 fpu_done,
  input  logic                 fpu_overflow
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_e       state_q;
  fpu_cmd_t           cmd_q;
  fpu_rsp_t           rsp_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [NUM_REQ-1:0] grant_oh_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic               strobe_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  fpu_cmd_t           sel_cmd;
  logic               accept;
  logic               done_rise;
  logic               timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i         (req_valid),
    .last_grant_i  (last_grant_q),
    .grant_o       (arb_grant),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid)
  );

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_cmd.op1    = req_op1[32*i +: 32];
        sel_cmd.op2    = req_op2[32*i +: 32];
        sel_cmd.op_sel = req_op_sel[3*i +: 3];
      end
    end
  end

  // Ready is gated by reset as well so every output reads 0 while n_rst is low.
  assign req_ready   = (n_rst && state_q == ST_IDLE) ? arb_grant : '0;
  assign accept      = (state_q == ST_IDLE) && arb_valid;
  assign done_rise   = fpu_done && !done_q;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      rsp_q        <= '0;
      grant_idx_q  <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      rsp_valid_q  <= '0;
      strobe_q     <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      strobe_q    <= 1'b0;
      rsp_valid_q <= '0;
      done_q      <= fpu_done;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_q       <= sel_cmd;
            grant_idx_q <= arb_idx;
            grant_oh_q  <= arb_grant;
            if (is_legal_op(sel_cmd.op_sel)) begin
              strobe_q <= 1'b1;
              state_q  <= ST_ISSUE;
            end else begin
              rsp_q.result   <= '0;
              rsp_q.overflow <= 1'b0;
              rsp_q.err      <= ERR_ILLEGAL;
              rsp_valid_q    <= arb_grant;
              state_q        <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done level carried over from the previous op never forms an edge.
          if (done_rise) begin
            rsp_q.result   <= fpu_result;
            rsp_q.overflow <= fpu_overflow;
            rsp_q.err      <= ERR_OK;
            rsp_valid_q    <= grant_oh_q;
            state_q        <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_q.result   <= '0;
            rsp_q.overflow <= 1'b0;
            rsp_q.err      <= ERR_TIMEOUT;
            rsp_valid_q    <= grant_oh_q;
            state_q        <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          last_grant_q <= grant_idx_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_q.result;
  assign rsp_overflow  = rsp_q.overflow;
  assign rsp_err       = rsp_q.err;
  assign fpu_op1       = cmd_q.op1;
  assign fpu_op2       = cmd_q.op2;
  assign fpu_op_sel    = cmd_q.op_sel;
  assign fpu_op_strobe = strobe_q;

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Scoreboard bench for fpu_rr_scheduler: directed ops, a behavioural FPU model,
// an acceptance watcher that queues expected responses and a response monitor.
`timescale 1ns/1ps
module tb_fpu_rr_scheduler;
  import fpu_pkg::*;

  localparam int NUM_REQ        = 2;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_W          = 5;
  localparam int LAT_FPU        = 7;
  localparam int LAT_TMO        = TIMEOUT_CYCLES + 2;
  localparam int LAT_ILL        = 1;

  logic                  clk = 1'b0;
  logic                  n_rst = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*32-1:0] req_op1 = '0;
  logic [NUM_REQ*32-1:0] req_op2 = '0;
  logic [NUM_REQ*3-1:0]  req_op_sel = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_result;
  logic                  rsp_overflow;
  logic [1:0]            rsp_err;
  logic [31:0]           fpu_op1;
  logic [31:0]           fpu_op2;
  logic [2:0]            fpu_op_sel;
  logic                  fpu_op_strobe;
  logic [31:0]           fpu_result = '0;
  logic                  fpu_done = 1'b0;
  logic                  fpu_overflow = 1'b0;

  fpu_rr_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .req_valid     (req_valid),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .req_op_sel    (req_op_sel),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .rsp_overflow  (rsp_overflow),
    .rsp_err       (rsp_err),
    .fpu_op1       (fpu_op1),
    .fpu_op2       (fpu_op2),
    .fpu_op_sel    (fpu_op_sel),
    .fpu_op_strobe (fpu_op_strobe),
    .fpu_result    (fpu_result),
    .fpu_done      (fpu_done),
    .fpu_overflow  (fpu_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        ovf;
    logic [1:0]  err;
    int          at_cyc;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_strobe = 0;
  int   acc_cyc = -10;
  int   acc_idx = 0;

  logic [31:0] e_op1 [NUM_REQ];
  logic [31:0] e_op2 [NUM_REQ];
  logic [2:0]  e_sel [NUM_REQ];
  logic [31:0] e_res [NUM_REQ];
  logic        e_ovf [NUM_REQ];
  logic [1:0]  e_err [NUM_REQ];
  int          e_lat [NUM_REQ];

  logic [31:0] model_res = '0;
  logic        model_ovf = 1'b0;
  logic        model_hold = 1'b0;
  logic        model_hang = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Acceptance watcher: queues the expected response and checks the issue strobe.
  initial forever begin
    @(negedge clk);
    if (n_rst) begin
      if (req_ready != '0) check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.idx    = i;
          e.res    = e_res[i];
          e.ovf    = e_ovf[i];
          e.err    = e_err[i];
          e.at_cyc = cyc + e_lat[i];
          sb.push_back(e);
          grants.push_back(i);
          acc_cyc = cyc;
          acc_idx = i;
        end
      end
      if (fpu_op_strobe) begin
        n_strobe++;
        check("strobe_cycle", cyc, acc_cyc + 1);
        check("fpu_op1", fpu_op1, e_op1[acc_idx]);
        check("fpu_op2", fpu_op2, e_op2[acc_idx]);
        check("fpu_op_sel", 32'(fpu_op_sel), 32'(e_sel[acc_idx]));
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response pulse appears.
  initial forever begin
    @(negedge clk);
    if (n_rst && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        check("stray_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
        check("rsp_cycle", cyc, e.at_cyc);
        check("rsp_result", rsp_result, e.res);
        check("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // FPU model: a held-over done stays up two more cycles, then drops, and a fresh
  // done rises 5 cycles after the strobe.
  initial forever begin
    @(negedge clk);
    if (n_rst && fpu_op_strobe && !model_hang) begin
      repeat (3) @(posedge clk);
      #1 fpu_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      fpu_done     = 1'b1;
      fpu_result   = model_res;
      fpu_overflow = model_ovf;
      if (!model_hold) begin
        @(posedge clk);
        #1 fpu_done = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] sel, input logic [31:0] res, input logic ovf,
                         input logic [1:0] err, input int lat);
    e_op1[i] = a;
    e_op2[i] = b;
    e_sel[i] = sel;
    e_res[i] = res;
    e_ovf[i] = ovf;
    e_err[i] = err;
    e_lat[i] = lat;
    req_op1[32*i +: 32] = a;
    req_op2[32*i +: 32] = b;
    req_op_sel[3*i +: 3] = sel;
  endtask

  task automatic wait_accepts(input int n, input int budget);
    int start = grants.size();
    for (int k = 0; k < budget && grants.size() < start + n; k++) begin
      @(negedge clk);
      #1;
    end
    check("accept_count", grants.size() - start, n);
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_result"}, rsp_result, 32'd0);
    check({tag, "_rsp_overflow"}, 32'(rsp_overflow), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_fpu_op1"}, fpu_op1, 32'd0);
    check({tag, "_fpu_op2"}, fpu_op2, 32'd0);
    check({tag, "_fpu_op_sel"}, 32'(fpu_op_sel), 32'd0);
    check({tag, "_fpu_strobe"}, 32'(fpu_op_strobe), 32'd0);
  endtask

  initial begin
    int c0;
    int s0;
    int g0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, '0, '0, OP_ADD, '0, 1'b0, ERR_OK, LAT_FPU);

    // Power-on reset values
    repeat (2) @(negedge clk);
    check_all_zero("por");
    @(posedge clk);
    #1 n_rst = 1'b1;

    // Single add from requester 0
    @(posedge clk);
    #1;
    model_res = 32'h40C00000;
    model_ovf = 1'b0;
    set_req(0, 32'h40200000, 32'h40600000, OP_ADD, 32'h40C00000, 1'b0, ERR_OK, LAT_FPU);
    s0 = n_strobe;
    c0 = cyc;
    req_valid[0] = 1'b1;
    wait_accepts(1, 10);
    check("add_accept_cycle", acc_cyc, c0);
    check("add_grant", grants[$], 0);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_drain(40);
    check("add_strobes", n_strobe - s0, 1);

    // Illegal op from requester 1: no strobe, error response next cycle
    @(posedge clk);
    #1;
    set_req(1, 32'h12345678, 32'h9ABCDEF0, 3'b111, 32'h0, 1'b0, ERR_ILLEGAL, LAT_ILL);
    s0 = n_strobe;
    req_valid[1] = 1'b1;
    wait_accepts(1, 10);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_drain(20);
    check("illegal_strobes", n_strobe - s0, 0);

    // Both requesters continuously valid: grants rotate 0,1,0,1
    @(posedge clk);
    #1;
    model_res = 32'h3FF00000;
    set_req(0, 32'h3FA00000, 32'h3FC00000, OP_MUL, 32'h3FF00000, 1'b0, ERR_OK, LAT_FPU);
    set_req(1, 32'h3FA00000, 32'h3FC00000, OP_MUL, 32'h3FF00000, 1'b0, ERR_OK, LAT_FPU);
    g0 = grants.size();
    req_valid = '1;
    wait_accepts(4, 80);
    @(posedge clk);
    #1 req_valid = '0;
    wait_drain(40);
    for (int k = 0; k < 4; k++) begin
      if (g0 + k < grants.size()) check("rr_order", grants[g0 + k], k % 2);
    end

    // FPU never answers: timeout response with zero result
    @(posedge clk);
    #1;
    model_hang = 1'b1;
    set_req(0, 32'h40000000, 32'h3F800000, OP_SUB, 32'h0, 1'b0, ERR_TIMEOUT, LAT_TMO);
    req_valid[0] = 1'b1;
    wait_accepts(1, 10);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_drain(40);
    model_hang = 1'b0;

    // Op that leaves done high, then an overflow op that must wait for a fresh edge
    @(posedge clk);
    #1;
    model_hold = 1'b1;
    model_res  = 32'h40000000;
    set_req(1, 32'h3F800000, 32'h3F800000, OP_ADD, 32'h40000000, 1'b0, ERR_OK, LAT_FPU);
    req_valid[1] = 1'b1;
    wait_accepts(1, 10);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_drain(40);
    check("stale_done_level", 32'(fpu_done), 32'd1);
    model_hold = 1'b0;
    model_res  = 32'h7F800000;
    model_ovf  = 1'b1;
    set_req(0, 32'h7F000000, 32'h7F000000, OP_MUL, 32'h7F800000, 1'b1, ERR_OK, LAT_FPU);
    req_valid[0] = 1'b1;
    wait_accepts(1, 10);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_drain(40);
    model_ovf = 1'b0;

    // Reset in the middle of WAIT: outputs clear at once, no response, requester 0 first
    @(posedge clk);
    #1;
    model_hang = 1'b1;
    set_req(1, 32'h3F800000, 32'h40000000, OP_ADD, 32'h0, 1'b0, ERR_OK, LAT_FPU);
    req_valid[1] = 1'b1;
    wait_accepts(1, 10);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    repeat (6) @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    check_all_zero("midwait_rst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    model_hang = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    model_res = 32'h40C00000;
    set_req(0, 32'h40200000, 32'h40600000, OP_ADD, 32'h40C00000, 1'b0, ERR_OK, LAT_FPU);
    set_req(1, 32'h40200000, 32'h40600000, OP_ADD, 32'h40C00000, 1'b0, ERR_OK, LAT_FPU);
    g0 = grants.size();
    req_valid = '1;
    wait_accepts(1, 10);
    @(posedge clk);
    #1 req_valid = '0;
    if (g0 < grants.size()) check("post_rst_grant", grants[g0], 0);
    wait_drain(40);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
